// File: rtl/mxn_pipe_aligner.sv
// mxn_pipe_aligner: delays stream 0 by N cycles so it lines up with stream 1,
// pairs the aligned samples and buffers them in a DEPTH-entry FIFO.
// Sticky flags report dropped pairs (overflow) and disagreeing valids (mismatch).
module mxn_pipe_aligner #(
    parameter int M     = 3,
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid0,
    input  logic [M-1:0]             in0,
    input  logic                     in_valid1,
    input  logic [M-1:0]             in1,
    input  logic                     out_ready,
    input  logic                     flag_clr,
    output logic                     out_valid,
    output logic [M-1:0]             out0,
    output logic [M-1:0]             out1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     mismatch
);

    localparam int AW = $clog2(DEPTH);

    // stream 0 delay line, element k holds d[k+1]
    logic [N-1:0]        dv;
    logic [N-1:0][M-1:0] dd;

    // input concatenated below the line: tap[0] = input, tap[N] = d[N];
    // shifting by slicing keeps N = 1 legal without a special case
    logic [N:0]          vtap;
    logic [N:0][M-1:0]   dtap;

    logic [2*M-1:0]      mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;

    logic                push;
    logic                mis_evt;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                ovf_evt;
    logic [2*M-1:0]      head;

    assign vtap = {dv, in_valid0};
    assign dtap = {dd, in0};

    assign push    = vtap[N] & in_valid1;
    assign mis_evt = vtap[N] ^ in_valid1;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == (AW+1)'(DEPTH));
    // a full FIFO still accepts a push when the head leaves at the same edge
    assign wr_en     = push & (~full | pop);
    assign ovf_evt   = push & full & ~pop;

    assign head = mem[rptr];
    assign out0 = out_valid ? head[2*M-1:M] : '0;
    assign out1 = out_valid ? head[M-1:0]   : '0;

    // delay line shifts every cycle; no backpressure toward the inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv <= '0;
            dd <= '0;
        end else begin
            dv <= vtap[N-1:0];
            dd <= dtap[N-1:0];
        end
    end

    // FIFO storage; contents are only observed when count says they are valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= {dtap[N], in1};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // sticky flags; a new event at the same edge overrides flag_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            overflow <= ovf_evt | (overflow & ~flag_clr);
            mismatch <= mis_evt | (mismatch & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_mxn_pipe_aligner.sv
// Self-checking bench for mxn_pipe_aligner (M=3, N=4, DEPTH=4).
// Expected pairs are queued when the aligned stimulus is driven and compared
// when the DUT pops them.
module tb_mxn_pipe_aligner;

    localparam int M     = 3;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid0;
    logic [M-1:0]  in0;
    logic          in_valid1;
    logic [M-1:0]  in1;
    logic          out_ready;
    logic          flag_clr;
    logic          out_valid;
    logic [M-1:0]  out0;
    logic [M-1:0]  out1;
    logic [CW-1:0] count;
    logic          overflow;
    logic          mismatch;

    int checks;
    int errors;
    int pops;

    logic [2*M-1:0] sb[$];
    logic [M:0]     hist[$];

    mxn_pipe_aligner #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid0 (in_valid0),
        .in0       (in0),
        .in_valid1 (in_valid1),
        .in1       (in1),
        .out_ready (out_ready),
        .flag_clr  (flag_clr),
        .out_valid (out_valid),
        .out0      (out0),
        .out1      (out1),
        .count     (count),
        .overflow  (overflow),
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard monitor: sampled on the falling edge, pop happens at the next rising edge
    always @(negedge clk) begin
        logic [2*M-1:0] exp_pair;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got out0=%0d out1=%0d, expected no output", out0, out1);
                end else begin
                    exp_pair = sb.pop_front();
                    pops++;
                    if ({out0, out1} !== exp_pair) begin
                        errors++;
                        $display("FAIL sb_pair: got out0=%0d out1=%0d, expected out0=%0d out1=%0d",
                                 out0, out1, exp_pair[2*M-1:M], exp_pair[M-1:0]);
                    end
                end
            end else if (!out_valid) begin
                checks++;
                if ({out0, out1} !== '0) begin
                    errors++;
                    $display("FAIL idle_zero: got out0=%0d out1=%0d, expected 0 0", out0, out1);
                end
            end
        end
    end

    task automatic reset_model();
        sb.delete();
        hist.delete();
        repeat (N) hist.push_back('0);
    endtask

    // drive one cycle; queue the pair expected to be accepted at this edge
    task automatic drive(input logic v0, input logic [M-1:0] d0, input logic v1,
                         input logic [M-1:0] d1, input logic rdy, input logic clr);
        logic [M:0] tap;
        tap       = hist.pop_front();
        in_valid0 = v0;
        in0       = d0;
        in_valid1 = v1;
        in1       = d1;
        out_ready = rdy;
        flag_clr  = clr;
        if (tap[M] && v1 && (sb.size() < DEPTH || rdy)) begin
            sb.push_back({tap[M-1:0], d1});
        end
        hist.push_back({v0, d0});
        @(posedge clk);
        #1;
    endtask

    // k aligned pairs, one every gap cycles; pair j: in0 = base+j, in1 = base+j+3 (mod 8)
    // rdymode: 0 = never ready, 1 = always ready, 2 = ready on even cycles
    task automatic stream(input int k, input int gap, input int rdymode, input int base);
        int total;
        total = (k - 1) * gap + N + 1;
        for (int c = 0; c < total; c++) begin
            logic          v0;
            logic          v1;
            logic [M-1:0]  d0;
            logic [M-1:0]  d1;
            logic          rdy;
            v0  = (c % gap == 0) && (c / gap < k);
            v1  = (c >= N) && ((c - N) % gap == 0) && ((c - N) / gap < k);
            d0  = v0 ? M'(base + c / gap) : '0;
            d1  = v1 ? M'(base + (c - N) / gap + 3) : '0;
            rdy = (rdymode == 1) || (rdymode == 2 && (c % 2 == 0));
            drive(v0, d0, v1, d1, rdy, 1'b0);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid0 = 1'b0; in0 = '0; in_valid1 = 1'b0; in1 = '0;
        out_ready = 1'b0; flag_clr = 1'b0;
        reset_model();
        #2;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got count=%0d out_valid=%0b, expected 0 0", count, out_valid);
        end
        checks++;
        if (out0 !== '0 || out1 !== '0 || overflow !== 1'b0 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out0=%0d out1=%0d ovf=%0b mis=%0b, expected all 0",
                     out0, out1, overflow, mismatch);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got count=%0d out_valid=%0b, expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_align();
        drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL align_early: got out_valid=%0b, expected 0", out_valid);
        end
        drive(1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out0 !== 3'd5 || out1 !== 3'd2 || count !== CW'(1)) begin
            errors++;
            $display("FAIL align_out: got v=%0b out0=%0d out1=%0d count=%0d, expected 1 5 2 1",
                     out_valid, out0, out1, count);
        end
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL align_after: got v=%0b count=%0d, expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_fill_overflow();
        stream(5, 1, 0, 1);
        checks++;
        if (count !== CW'(4) || overflow !== 1'b1 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL fill_ovf: got count=%0d ovf=%0b mis=%0b, expected 4 1 0", count, overflow, mismatch);
        end
        checks++;
        if (out0 !== 3'd1 || out1 !== 3'd4) begin
            errors++;
            $display("FAIL fill_head: got out0=%0d out1=%0d, expected 1 4", out0, out1);
        end
        drain(6);
        checks++;
        if (count !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL fill_drain: got count=%0d pending=%0d, expected 0 0", count, sb.size());
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %0b, expected 1", overflow);
        end
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %0b, expected 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        stream(4, 1, 0, 1);
        checks++;
        if (count !== CW'(4) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pre: got count=%0d ovf=%0b, expected 4 0", count, overflow);
        end
        drive(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(4) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: got count=%0d ovf=%0b, expected 4 0", count, overflow);
        end
        checks++;
        if (out0 !== 3'd2 || out1 !== 3'd5) begin
            errors++;
            $display("FAIL full_head: got out0=%0d out1=%0d, expected 2 5", out0, out1);
        end
        drain(6);
        checks++;
        if (count !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got count=%0d pending=%0d, expected 0 0", count, sb.size());
        end
    endtask

    task automatic test_mismatch();
        drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mis_early: got %0b, expected 0", mismatch);
        end
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        checks++;
        if (mismatch !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL mis_set0: got mis=%0b count=%0d, expected 1 0", mismatch, count);
        end
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mis_clr: got %0b, expected 0", mismatch);
        end
        drive(1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 1'b0);
        checks++;
        if (mismatch !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL mis_set1: got mis=%0b count=%0d, expected 1 0", mismatch, count);
        end
        drive(1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 1'b1);
        checks++;
        if (mismatch !== 1'b1) begin
            errors++;
            $display("FAIL mis_set_wins: got %0b, expected 1", mismatch);
        end
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mis_clr2: got %0b, expected 0", mismatch);
        end
    endtask

    task automatic test_reset_mid();
        stream(3, 1, 0, 2);
        drive(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL rmid_pre: got count=%0d, expected 3", count);
        end
        #2;
        rst_n = 1'b0;
        in_valid0 = 1'b0; in0 = '0; in_valid1 = 1'b0; in1 = '0; out_ready = 1'b1; flag_clr = 1'b0;
        reset_model();
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || out0 !== '0 || out1 !== '0) begin
            errors++;
            $display("FAIL rmid_async: got count=%0d v=%0b out0=%0d out1=%0d, expected 0 0 0 0",
                     count, out_valid, out0, out1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet: cycle %0d got out_valid=%0b, expected 0", i, out_valid);
            end
        end
        checks++;
        if (mismatch !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_flags: got mis=%0b ovf=%0b, expected 0 0", mismatch, overflow);
        end
    endtask

    task automatic test_wrap();
        int pops0;
        pops0 = pops;
        stream(10, 2, 2, 0);
        drain(4);
        checks++;
        if (pops - pops0 != 10 || sb.size() != 0 || count !== '0) begin
            errors++;
            $display("FAIL wrap_all: got popped=%0d pending=%0d count=%0d, expected 10 0 0",
                     pops - pops0, sb.size(), count);
        end
        checks++;
        if (overflow !== 1'b0 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flags: got ovf=%0b mis=%0b, expected 0 0", overflow, mismatch);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pops   = 0;
        test_reset();
        test_align();
        test_fill_overflow();
        test_full_pop();
        test_mismatch();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
